// File: rtl/kronos_lsu_seq.sv
// Load/store unit sequencer: accepts one memory op from execute, runs a single
// bus transaction with timeout, and returns aligned/extended load data for writeback.
module kronos_lsu_seq #(
    parameter int unsigned BUS_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ex_vld,
    output logic        ex_rdy,
    input  logic        ex_ld,
    input  logic        ex_st,
    input  logic [1:0]  ex_size,
    input  logic        ex_uns,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,

    output logic        data_req,
    output logic        data_we,
    output logic [31:0] data_addr,
    output logic [3:0]  data_mask,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        data_ack,

    output logic        wb_vld,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,

    output logic        err_misalign,
    output logic        err_bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    // Attributes of the in-flight op needed to shape the load result.
    logic             op_ld;
    logic [4:0]       op_rd;
    logic [1:0]       op_size;
    logic             op_uns;
    logic [1:0]       op_off;

    logic             accept;
    logic             misaligned;
    logic [3:0]       mask_nxt;
    logic [31:0]      wdata_nxt;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;

    assign ex_rdy   = (state == IDLE) && !rst;
    assign accept   = ex_vld && ex_rdy && (ex_ld || ex_st);
    assign data_req = (state == BUSY);

    always_comb begin
        misaligned = 1'b0;
        mask_nxt   = 4'b1111;
        wdata_nxt  = ex_wdata;
        case (ex_size)
            2'b00: begin
                mask_nxt  = 4'b0001 << ex_addr[1:0];
                wdata_nxt = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = ex_addr[0];
                mask_nxt   = 4'b0011 << {ex_addr[1], 1'b0};
                wdata_nxt  = {2{ex_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = (ex_addr[1:0] != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    always_comb begin
        ld_byte = data_rdata[7:0];
        case (op_off)
            2'd0: ld_byte = data_rdata[7:0];
            2'd1: ld_byte = data_rdata[15:8];
            2'd2: ld_byte = data_rdata[23:16];
            default: ld_byte = data_rdata[31:24];
        endcase
        ld_half = op_off[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (op_size)
            2'b00:   ld_data = {{24{~op_uns & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~op_uns & ld_half[15]}}, ld_half};
            default: ld_data = data_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            op_ld        <= 1'b0;
            op_rd        <= '0;
            op_size      <= '0;
            op_uns       <= 1'b0;
            op_off       <= '0;
            data_we      <= 1'b0;
            data_addr    <= '0;
            data_mask    <= '0;
            data_wdata   <= '0;
            wb_vld       <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            err_misalign <= 1'b0;
            err_bus      <= 1'b0;
        end else begin
            wb_vld       <= 1'b0;
            err_misalign <= 1'b0;
            err_bus      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            err_misalign <= 1'b1;
                        end else begin
                            state      <= BUSY;
                            cnt        <= '0;
                            op_ld      <= ex_ld;
                            op_rd      <= ex_rd;
                            op_size    <= ex_size;
                            op_uns     <= ex_uns;
                            op_off     <= ex_addr[1:0];
                            // ld wins when both are set, so a write needs ld low.
                            data_we    <= !ex_ld;
                            data_addr  <= {ex_addr[31:2], 2'b00};
                            data_mask  <= mask_nxt;
                            data_wdata <= wdata_nxt;
                        end
                    end
                end
                default: begin
                    if (data_ack) begin
                        state <= IDLE;
                        if (op_ld && (op_rd != 5'd0)) begin
                            wb_vld  <= 1'b1;
                            wb_rd   <= op_rd;
                            wb_data <= ld_data;
                        end
                    end else if ((BUS_TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        state   <= IDLE;
                        err_bus <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kronos_lsu_seq.sv
// Self-checking bench for kronos_lsu_seq: directed vector table, reset/ignore
// sequences and randomized ops checked against a transaction-level model.
module tb_kronos_lsu_seq;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_vld, ex_rdy, ex_ld, ex_st, ex_uns;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        data_req, data_we, data_ack;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_mask;
    logic        wb_vld;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_misalign, err_bus;

    kronos_lsu_seq #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_vld(ex_vld), .ex_rdy(ex_rdy), .ex_ld(ex_ld), .ex_st(ex_st),
        .ex_size(ex_size), .ex_uns(ex_uns), .ex_addr(ex_addr),
        .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_mask(data_mask), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ack(data_ack),
        .wb_vld(wb_vld), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_misalign(err_misalign), .err_bus(err_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int unsigned ack_dly;
        logic [31:0] rdata;
        logic        exp_mis;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic        exp_wb;
        logic [31:0] exp_wb_data;
        logic        exp_ebus;
    } vec_t;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [4:0]  last_rd = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: byte-lane arithmetic straight from the access rules.
    function automatic logic model_mis(input logic [1:0] size, input logic [31:0] a);
        int unsigned nb;
        if (size == 2'b11) return 1'b1;
        nb = 1 << size;
        return (a % nb) != 0;
    endfunction

    function automatic logic [3:0] model_mask(input logic [1:0] size, input logic [31:0] a);
        int unsigned nb = 1 << size;
        int unsigned off = a % 4;
        logic [3:0] m = '0;
        for (int unsigned i = 0; i < 4; i++)
            m[i] = (i >= off) && (i < off + nb);
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
        int unsigned nb = 1 << size;
        logic [31:0] r = '0;
        for (int unsigned i = 0; i < 4; i++)
            r = r | (((w >> (8 * (i % nb))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] model_ld(input logic [1:0] size, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rdata);
        int unsigned nb = 1 << size;
        int unsigned off = a % 4;
        longint one = 1;
        longint v;
        v = (longint'(rdata) >> (8 * off)) & ((one << (8 * nb)) - 1);
        if (!uns && v >= (one << (8 * nb - 1)))
            v = v - (one << (8 * nb));
        return v[31:0];
    endfunction

    function automatic vec_t model_fill(input vec_t v);
        vec_t r = v;
        r.exp_mis     = model_mis(v.size, v.addr);
        r.exp_mask    = r.exp_mis ? 4'b0000 : model_mask(v.size, v.addr);
        r.exp_wdata   = r.exp_mis ? 32'h0 : model_wdata(v.size, v.wdata);
        r.exp_ebus    = !r.exp_mis && (v.ack_dly >= TO);
        r.exp_wb      = !r.exp_mis && !r.exp_ebus && v.ld && (v.rd != 5'd0);
        r.exp_wb_data = r.exp_wb ? model_ld(v.size, v.uns, v.addr, v.rdata) : 32'h0;
        return r;
    endfunction

    task automatic idle_inputs;
        ex_vld = 1'b0; ex_ld = 1'($urandom_range(0, 1)); ex_st = 1'($urandom_range(0, 1));
        ex_size = 2'($urandom); ex_uns = 1'($urandom_range(0, 1));
        ex_addr = $urandom; ex_wdata = $urandom; ex_rd = 5'($urandom);
    endtask

    // Entered and left at posedge+1.
    task automatic run_op(input vec_t v, input string tag);
        int unsigned busy;
        ex_vld = 1'b1; ex_ld = v.ld; ex_st = v.st; ex_size = v.size; ex_uns = v.uns;
        ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd;
        data_ack = 1'b0;
        @(negedge clk);
        chk({tag, ".rdy_accept"}, 32'(ex_rdy), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        if (v.exp_mis) begin
            @(negedge clk);
            chk({tag, ".mis_pulse"}, 32'(err_misalign), 32'd1);
            chk({tag, ".mis_noreq"}, 32'(data_req), 32'd0);
            chk({tag, ".mis_rdy"}, 32'(ex_rdy), 32'd1);
            chk({tag, ".mis_nowb"}, 32'({wb_vld, err_bus}), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, ".mis_one_cycle"}, 32'(err_misalign), 32'd0);
            chk({tag, ".mis_noreq2"}, 32'(data_req), 32'd0);
            @(posedge clk); #1;
        end else begin
            busy = v.exp_ebus ? TO : v.ack_dly + 1;
            for (int unsigned k = 0; k < busy; k++) begin
                data_ack   = (k == v.ack_dly);
                data_rdata = (k == v.ack_dly) ? v.rdata : $urandom;
                @(negedge clk);
                chk({tag, ".req"}, 32'(data_req), 32'd1);
                chk({tag, ".busy_rdy"}, 32'(ex_rdy), 32'd0);
                chk({tag, ".busy_pulses"}, 32'({wb_vld, err_bus, err_misalign}), 32'd0);
                if (k == 0) begin
                    chk({tag, ".addr"}, data_addr, {v.addr[31:2], 2'b00});
                    chk({tag, ".mask"}, 32'(data_mask), 32'(v.exp_mask));
                    chk({tag, ".wdata"}, data_wdata, v.exp_wdata);
                    chk({tag, ".we"}, 32'(data_we), 32'(!v.ld));
                end
                @(posedge clk); #1;
            end
            data_ack = 1'b0; data_rdata = $urandom;
            @(negedge clk);
            chk({tag, ".req_drop"}, 32'(data_req), 32'd0);
            chk({tag, ".rdy_after"}, 32'(ex_rdy), 32'd1);
            chk({tag, ".wb_vld"}, 32'(wb_vld), 32'(v.exp_wb));
            chk({tag, ".err_bus"}, 32'(err_bus), 32'(v.exp_ebus));
            chk({tag, ".no_mis"}, 32'(err_misalign), 32'd0);
            if (v.exp_wb) begin
                last_rd = v.rd;
                last_data = v.exp_wb_data;
            end
            chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(last_rd));
            chk({tag, ".wb_data"}, wb_data, last_data);
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, ".pulse_end"}, 32'({wb_vld, err_bus}), 32'd0);
            chk({tag, ".wb_data_hold"}, wb_data, last_data);
            @(posedge clk); #1;
        end
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        // ld st size uns addr wdata rd dly rdata | mis mask wdata wb wb_data ebus
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 5'd5, 2, 32'h80112233,
                    1'b0, 4'b1000, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000BEEF, 5'd0, 1, 32'h0,
                    1'b0, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 5'd6, 0, 32'h0,
                    1'b1, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 5'd3, 10, 32'h0,
                    1'b0, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 5'd3, 3, 32'hCAFEF00D,
                    1'b0, 4'b1111, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h1000, 32'h0, 5'd0, 0, 32'h000000FF,
                    1'b0, 4'b0001, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h5000, 32'h12345678, 5'd0, 0, 32'h0,
                    1'b1, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 5'd7, 0, 32'h80010000,
                    1'b0, 4'b1100, 32'h0, 1'b1, 32'h00008001, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 5'd8, 1, 32'h00008001,
                    1'b0, 4'b0011, 32'h0, 1'b1, 32'hFFFF8001, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h5001, 32'h123456A5, 5'd1, 0, 32'h0,
                    1'b0, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h6000, 32'h0, 5'd9, 2, 32'h11223344,
                    1'b0, 4'b1111, 32'h0, 1'b1, 32'h11223344, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h1002, 32'h0, 5'd31, 0, 32'h80112233,
                    1'b0, 4'b0100, 32'h0, 1'b1, 32'h00000011, 1'b0};

        rst = 1'b1; idle_inputs(); data_ack = 1'b0; data_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.rdy_low", 32'(ex_rdy), 32'd0);
        chk("rst.req", 32'({data_req, data_we, data_mask}), 32'd0);
        chk("rst.addr", data_addr, 32'h0);
        chk("rst.wdata", data_wdata, 32'h0);
        chk("rst.wb", 32'({wb_vld, wb_rd, err_misalign, err_bus}), 32'd0);
        chk("rst.wb_data", wb_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op(tbl[i], $sformatf("vec%0d", i));

        // Valid without ld/st must be ignored.
        ex_vld = 1'b1; ex_ld = 1'b0; ex_st = 1'b0; ex_size = 2'b11; ex_addr = 32'h7;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("ignore.rdy", 32'(ex_rdy), 32'd1);
            chk("ignore.quiet", 32'({data_req, err_misalign, wb_vld, err_bus}), 32'd0);
            @(posedge clk); #1;
        end
        idle_inputs();

        // Reset in the 2nd BUSY cycle with a simultaneous ack.
        ex_vld = 1'b1; ex_ld = 1'b1; ex_st = 1'b0; ex_size = 2'b10; ex_uns = 1'b0;
        ex_addr = 32'h100; ex_wdata = 32'h55; ex_rd = 5'd4;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("rstbusy.req1", 32'(data_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; data_ack = 1'b1; data_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rstbusy.rdy_low", 32'(ex_rdy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; data_ack = 1'b0;
        @(negedge clk);
        chk("rstbusy.ctrl", 32'({data_req, data_we, data_mask}), 32'd0);
        chk("rstbusy.addr", data_addr, 32'h0);
        chk("rstbusy.wdata", data_wdata, 32'h0);
        chk("rstbusy.pulses", 32'({wb_vld, wb_rd, err_misalign, err_bus}), 32'd0);
        chk("rstbusy.wb_data", wb_data, 32'h0);
        chk("rstbusy.rdy", 32'(ex_rdy), 32'd1);
        last_rd = '0; last_data = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstbusy.no_late_wb", 32'({wb_vld, err_bus, data_req}), 32'd0);
        @(posedge clk); #1;
        run_op(tbl[7], "post_rst");

        for (int i = 0; i < 60; i++) begin
            rv.ld   = 1'($urandom_range(0, 1));
            rv.st   = rv.ld ? 1'($urandom_range(0, 1)) : 1'b1;
            rv.size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rv.uns  = 1'($urandom_range(0, 1));
            rv.addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rv.size == 2'b01) rv.addr[0] = 1'b0;
                if (rv.size == 2'b10) rv.addr[1:0] = 2'b00;
            end
            rv.wdata   = $urandom;
            rv.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rv.ack_dly = $urandom_range(0, 5);
            rv.rdata   = $urandom;
            rv = model_fill(rv);
            run_op(rv, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
